// File: rtl/wb_dcache_evict_buffer.sv
// rtl/wb_dcache_evict_buffer.sv - write-back buffer draining dirty victim lines as AXI4 INCR bursts
module wb_dcache_evict_buffer #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int LineWidth = 128,
    parameter int IdWidth   = 4,
    parameter int AxiId     = 0,
    parameter int Depth     = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   evict_valid_i,
    output logic                   evict_ready_o,
    input  logic [AddrWidth-1:0]   evict_addr_i,
    input  logic [LineWidth-1:0]   evict_data_i,
    input  logic [AddrWidth-1:0]   chk_addr_i,
    output logic                   chk_hit_o,
    output logic                   aw_valid_o,
    input  logic                   aw_ready_i,
    output logic [AddrWidth-1:0]   aw_addr_o,
    output logic [IdWidth-1:0]     aw_id_o,
    output logic [7:0]             aw_len_o,
    output logic [2:0]             aw_size_o,
    output logic [1:0]             aw_burst_o,
    output logic                   w_valid_o,
    input  logic                   w_ready_i,
    output logic [DataWidth-1:0]   w_data_o,
    output logic [DataWidth/8-1:0] w_strb_o,
    output logic                   w_last_o,
    input  logic                   b_valid_i,
    output logic                   b_ready_o,
    input  logic [1:0]             b_resp_i,
    output logic                   empty_o,
    output logic                   err_o
);

    localparam int Beats = LineWidth / DataWidth;
    localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW  = $clog2(Depth + 1);
    localparam int OffW  = $clog2(LineWidth / 8);
    localparam int LineW = AddrWidth - OffW;

    typedef enum logic [1:0] {
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

    state_t           state, state_n;
    logic [LineW-1:0] line_mem [Depth];
    logic [LineWidth-1:0] data_mem [Depth];
    logic [Depth-1:0] vld;
    logic [PtrW-1:0]  wr_ptr, rd_ptr;
    logic [CntW-1:0]  count;
    logic [BeatW-1:0] beat;
    logic             push, pop, aw_hs, w_hs;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign evict_ready_o = (count != CntW'(Depth));
    assign empty_o       = (count == '0);
    assign push          = evict_valid_i && evict_ready_o;
    assign pop           = (state == ST_RESP) && b_valid_i;
    assign aw_hs         = aw_valid_o && aw_ready_i;
    assign w_hs          = w_valid_o && w_ready_i;

    // Constant burst attributes; the address drops the in-line offset bits.
    assign aw_addr_o  = {line_mem[rd_ptr], {OffW{1'b0}}};
    assign aw_id_o    = IdWidth'(AxiId);
    assign aw_len_o   = 8'(Beats - 1);
    assign aw_size_o  = 3'($clog2(DataWidth / 8));
    assign aw_burst_o = 2'b01;
    assign w_strb_o   = '1;
    assign w_data_o   = data_mem[rd_ptr][int'(beat) * DataWidth +: DataWidth];
    assign w_last_o   = (beat == BeatW'(Beats - 1));

    // Line storage; contents need no reset since vld/count gate every use.
    always_ff @(posedge clk_i) begin
        if (push) begin
            line_mem[wr_ptr] <= evict_addr_i[AddrWidth-1:OffW];
            data_mem[wr_ptr] <= evict_data_i;
        end
    end

    // Occupancy bookkeeping: entries live from push until their B handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld    <= '0;
        end else begin
            if (pop) begin
                rd_ptr      <= next_ptr(rd_ptr);
                vld[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr      <= next_ptr(wr_ptr);
                vld[wr_ptr] <= 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Drain state and beat counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_ADDR;
            beat  <= '0;
        end else begin
            state <= state_n;
            if (aw_hs) begin
                beat <= '0;
            end else if (w_hs && !w_last_o) begin
                beat <= beat + 1'b1;
            end
        end
    end

    // Drain FSM: one burst outstanding, AW before W, entry freed on B.
    always_comb begin
        state_n    = state;
        aw_valid_o = 1'b0;
        w_valid_o  = 1'b0;
        b_ready_o  = 1'b0;
        err_o      = 1'b0;
        unique case (state)
            ST_ADDR: begin
                aw_valid_o = !empty_o;
                if (aw_valid_o && aw_ready_i) begin
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                w_valid_o = 1'b1;
                if (w_ready_i && w_last_o) begin
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                b_ready_o = 1'b1;
                if (b_valid_i) begin
                    err_o   = b_resp_i[1];
                    state_n = ST_ADDR;
                end
            end
            default: state_n = ST_ADDR;
        endcase
    end

    // Line-granular probe against pending entries and a same-cycle push.
    always_comb begin
        chk_hit_o = push && (evict_addr_i[AddrWidth-1:OffW] == chk_addr_i[AddrWidth-1:OffW]);
        for (int i = 0; i < Depth; i++) begin
            if (vld[i] && (line_mem[i] == chk_addr_i[AddrWidth-1:OffW])) begin
                chk_hit_o = 1'b1;
            end
        end
    end

endmodule
